// File: rtl/pong_pkg.sv
// Shared encodings for the ball engine: FSM phase codes, ball directions and grid sizing.
// BALL_SPEEDUP_EN (optional) enables the hit-driven speed-up in ball_engine and game_tick.
package pong_pkg;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_PLAY = 2'd1,
    PH_MISS = 2'd2,
    PH_OVER = 2'd3
  } phase_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_x_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_y_t;

  // Largest tick-period shift reachable by the speed-up (period floor is TICK_DIV/4).
  localparam logic [1:0] SPEED_MAX = 2'd2;

  // Number of cells along an axis indexed with 'bits' bits.
  function automatic int grid_span(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/game_tick.sv
// Enable-gated game tick divider; with BALL_SPEEDUP_EN a shift input shortens the period.
module game_tick #(
  parameter int TICK_DIV  = 12500000,
  parameter int TICK_BITS = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
`ifdef BALL_SPEEDUP_EN
  input  logic [1:0] shift,
`endif
  output logic tick
);

  localparam logic [TICK_BITS-1:0] DIV = TICK_BITS'(TICK_DIV);

  logic [TICK_BITS-1:0] count_reg;
  logic [TICK_BITS-1:0] count_next;
  logic [TICK_BITS-1:0] period;
  logic [TICK_BITS-1:0] limit;

`ifdef BALL_SPEEDUP_EN
  logic [TICK_BITS-1:0] shifted;
  assign shifted = DIV >> shift;
  assign period  = (shifted == '0) ? TICK_BITS'(1) : shifted;
`else
  assign period = DIV;
`endif

  assign limit = period - 1'b1;
  // >= rather than == so a count left over from a slower period still wraps.
  assign tick  = run && (count_reg >= limit);

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (run) begin
      count_next = tick ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Ball motion, wall/paddle reflection, miss/lives and serve/game-over sequencing.
// Optional macro BALL_SPEEDUP_EN: every 4 paddle hits halve the tick period (floor TICK_DIV/4).
module ball_engine
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH   = 3,
  parameter int ROW_BITS    = 3,
  parameter int SIZE        = 2,
  parameter int SERVE_X     = 3,
  parameter int START_LIVES = 3,
  parameter int TICK_DIV    = 12500000,
  parameter int TICK_BITS   = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 serve,
  input  logic [BIT_WIDTH-1:0] state_left,
  output logic [BIT_WIDTH-1:0] ball_x,
  output logic [ROW_BITS-1:0]  ball_y,
  output logic                 hit,
  output logic                 miss,
  output logic [1:0]           lives,
  output logic                 game_over,
  output logic [1:0]           phase
);

  localparam int COLS = grid_span(BIT_WIDTH);
  localparam int ROWS = grid_span(ROW_BITS);

  localparam logic [BIT_WIDTH-1:0] MAX_X    = BIT_WIDTH'(COLS - 1);
  localparam logic [BIT_WIDTH-1:0] SERVE_C  = BIT_WIDTH'(SERVE_X);
  localparam logic [ROW_BITS-1:0]  PADDLE_Y = ROW_BITS'(ROWS - 2);
  localparam logic [ROW_BITS-1:0]  BOTTOM_Y = ROW_BITS'(ROWS - 1);
  localparam logic [1:0]           LIVES0   = 2'(START_LIVES);

  phase_t               state_reg, state_next;
  logic [BIT_WIDTH-1:0] x_reg, x_next;
  logic [ROW_BITS-1:0]  y_reg, y_next;
  dir_x_t               dx_reg, dx_next;
  dir_y_t               dy_reg, dy_next;
  logic [1:0]           lives_reg, lives_next;
  logic                 hit_reg, hit_next;
  logic                 miss_reg, miss_next;

  logic tick;
  logic tick_run;
  logic tick_clear;

  assign tick_run   = en && ((state_reg == PH_PLAY) || (state_reg == PH_MISS));
  assign tick_clear = (state_reg == PH_IDLE) || (state_reg == PH_OVER);

`ifdef BALL_SPEEDUP_EN
  logic [1:0] hit_cnt_reg, hit_cnt_next;
  logic [1:0] speed_reg, speed_next;
`endif

  game_tick #(
    .TICK_DIV  (TICK_DIV),
    .TICK_BITS (TICK_BITS)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .run   (tick_run),
    .clear (tick_clear),
`ifdef BALL_SPEEDUP_EN
    .shift (speed_reg),
`endif
    .tick  (tick)
  );

  // Reflection is resolved before the step, so the step always uses the new direction.
  dir_x_t               dx_ref;
  dir_y_t               dy_ref;
  logic [BIT_WIDTH-1:0] x_step;
  logic [BIT_WIDTH:0]   pad_lo, pad_hi, x_wide;
  logic                 in_range;

  assign dx_ref = ((x_reg == MAX_X) && (dx_reg == DIR_RIGHT)) ? DIR_LEFT :
                  ((x_reg == '0) && (dx_reg == DIR_LEFT))     ? DIR_RIGHT : dx_reg;
  assign dy_ref = ((y_reg == '0) && (dy_reg == DIR_UP)) ? DIR_DOWN : dy_reg;
  assign x_step = (dx_ref == DIR_RIGHT) ? x_reg + 1'b1 : x_reg - 1'b1;

  // One extra bit so a paddle hanging past the right wall does not wrap around.
  assign pad_lo   = {1'b0, state_left};
  assign pad_hi   = pad_lo + (BIT_WIDTH+1)'(SIZE - 1);
  assign x_wide   = {1'b0, x_step};
  assign in_range = (x_wide >= pad_lo) && (x_wide <= pad_hi);

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    dx_next    = dx_reg;
    dy_next    = dy_reg;
    lives_next = lives_reg;
    hit_next   = 1'b0;
    miss_next  = 1'b0;
`ifdef BALL_SPEEDUP_EN
    hit_cnt_next = hit_cnt_reg;
    speed_next   = speed_reg;
`endif
    case (state_reg)
      PH_IDLE: begin
        x_next  = SERVE_C;
        y_next  = '0;
        dx_next = DIR_RIGHT;
        dy_next = DIR_DOWN;
        if (serve && en) begin
          state_next = PH_PLAY;
        end
      end
      PH_PLAY: begin
        if (tick) begin
          x_next  = x_step;
          dx_next = dx_ref;
          dy_next = dy_ref;
          if ((y_reg == PADDLE_Y) && (dy_ref == DIR_DOWN)) begin
            if (in_range) begin
              dy_next  = DIR_UP;
              y_next   = y_reg - 1'b1;
              hit_next = 1'b1;
`ifdef BALL_SPEEDUP_EN
              hit_cnt_next = hit_cnt_reg + 2'd1;
              if ((hit_cnt_reg == 2'd3) && (speed_reg != SPEED_MAX)) begin
                speed_next = speed_reg + 2'd1;
              end
`endif
            end else begin
              y_next     = BOTTOM_Y;
              miss_next  = 1'b1;
              lives_next = lives_reg - 2'd1;
              state_next = PH_MISS;
`ifdef BALL_SPEEDUP_EN
              hit_cnt_next = 2'd0;
              speed_next   = 2'd0;
`endif
            end
          end else begin
            y_next = (dy_ref == DIR_DOWN) ? y_reg + 1'b1 : y_reg - 1'b1;
          end
        end
      end
      PH_MISS: begin
        if (tick) begin
          if (lives_reg == 2'd0) begin
            state_next = PH_OVER;
          end else begin
            state_next = PH_IDLE;
            x_next     = SERVE_C;
            y_next     = '0;
            dx_next    = DIR_RIGHT;
            dy_next    = DIR_DOWN;
          end
        end
      end
      PH_OVER: begin
        if (serve) begin
          state_next = PH_IDLE;
          lives_next = LIVES0;
          x_next     = SERVE_C;
          y_next     = '0;
          dx_next    = DIR_RIGHT;
          dy_next    = DIR_DOWN;
`ifdef BALL_SPEEDUP_EN
          hit_cnt_next = 2'd0;
          speed_next   = 2'd0;
`endif
        end
      end
      default: state_next = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= PH_IDLE;
      x_reg     <= SERVE_C;
      y_reg     <= '0;
      dx_reg    <= DIR_RIGHT;
      dy_reg    <= DIR_DOWN;
      lives_reg <= LIVES0;
      hit_reg   <= 1'b0;
      miss_reg  <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      hit_cnt_reg <= 2'd0;
      speed_reg   <= 2'd0;
`endif
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      dx_reg    <= dx_next;
      dy_reg    <= dy_next;
      lives_reg <= lives_next;
      hit_reg   <= hit_next;
      miss_reg  <= miss_next;
`ifdef BALL_SPEEDUP_EN
      hit_cnt_reg <= hit_cnt_next;
      speed_reg   <= speed_next;
`endif
    end
  end

  assign ball_x    = x_reg;
  assign ball_y    = y_reg;
  assign hit       = hit_reg;
  assign miss      = miss_reg;
  assign lives     = lives_reg;
  assign game_over = (state_reg == PH_OVER);
  assign phase     = state_reg;

endmodule
